// File: rtl/iaaa_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
// Default widths, opcode set and arbiter FSM states.
package iaaa_pkg;

  localparam int N_CORES_D = 16;
  localparam int ADDR_W_D  = 16;
  localparam int DATA_W_D  = 16;
  localparam int DEPTH_D   = 64;

  localparam logic [DATA_W_D-1:0] NOP = '0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JMPZ = 4'hC;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } arb_state_t;

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches req & ~mask starting at ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  cand;
  logic [IW-1:0] j;
  logic          found;

  assign cand = req & ~mask;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!found && cand[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin sharing of one synchronous-read IRAM among fetch ports,
// with a host load port that takes the RAM once reads have drained.
module imem_fetch_arbiter
  import iaaa_pkg::*;
#(
  parameter int N_CORES = N_CORES_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int DEPTH   = DEPTH_D,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_CORES-1:0]    fetch_req,
  input  logic [N_CORES*ADDR_W-1:0] fetch_addr,
  output logic [N_CORES-1:0]    fetch_gnt,
  output logic [N_CORES-1:0]    rvalid,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  host_req,
  output logic                  host_gnt,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t state, state_n;

  logic [IW-1:0]      rr_ptr;
  logic [N_CORES-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      ptr_next;
  logic [ADDR_W-1:0]  win_addr;
  logic               win_oor;
  logic               host_oor;
  logic               take;
  logic               s1_valid;
  logic [IW-1:0]      s1_core;
  logic               s1_oor;
  logic               s2_valid;
  logic [IW-1:0]      s2_core;
  logic               s2_oor;

  rr_arbiter #(
    .N  (N_CORES),
    .IW (IW)
  ) u_arb (
    .req  (fetch_req),
    .mask (fetch_gnt),
    .ptr  (rr_ptr),
    .gnt  (win_gnt),
    .idx  (win_idx)
  );

  assign win_addr = fetch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_oor  = win_addr >= ADDR_W'(DEPTH);
  assign host_oor = host_addr >= ADDR_W'(DEPTH);
  assign take     = (state == RUN) && !host_req && (|win_gnt);
  assign s1_valid = |fetch_gnt;
  assign host_gnt = (state == LOAD);
  assign ptr_next = (win_idx == IW'(N_CORES - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (host_req) state_n = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_n = LOAD;
      LOAD:    if (!host_req) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      fetch_gnt <= '0;
      s1_core   <= '0;
      s1_oor    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take) begin
      rr_ptr    <= ptr_next;
      fetch_gnt <= win_gnt;
      s1_core   <= win_idx;
      s1_oor    <= win_oor;
      mem_en    <= !win_oor;
      mem_we    <= 1'b0;
      mem_addr  <= win_addr[AW-1:0];
    end else if (state == LOAD) begin
      fetch_gnt <= '0;
      mem_en    <= host_we && !host_oor;
      mem_we    <= host_we && !host_oor;
      mem_addr  <= host_addr[AW-1:0];
      mem_wdata <= host_wdata;
    end else begin
      fetch_gnt <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Out-of-range fetches ride the pipe with no RAM access and return NOP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_core  <= '0;
      s2_oor   <= 1'b0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_core  <= s1_core;
      s2_oor   <= s1_oor;
      rvalid   <= s2_valid ? (N_CORES'(1) << s2_core) : '0;
      rdata    <= (s2_valid && !s2_oor) ? mem_rdata : DATA_W'(NOP);
    end
  end

endmodule
